// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: stall-bus patterns,
// mul/div sequencer state encoding and a stall-pattern decode helper.
package pipe_stall_ctrl_pkg;

    // Stall bus bit meaning: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
    localparam int unsigned STALL_BUS_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // NONE: every stage advances
    localparam logic [STALL_BUS_W-1:0] STALL_NONE    = 6'b000000;
    // ID_HOLD: PC/IF/ID hold, EX receives a bubble
    localparam logic [STALL_BUS_W-1:0] STALL_ID_HOLD = 6'b000111;
    // EX_HOLD: PC/IF/ID/EX hold, MEM receives a bubble
    localparam logic [STALL_BUS_W-1:0] STALL_EX_HOLD = 6'b001111;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        MDS_IDLE  = 2'b00,
        MDS_START = 2'b01,
        MDS_WAIT  = 2'b10,
        MDS_DONE  = 2'b11
    } md_state_e;

    // Which stall pattern the output decode selects
    typedef enum logic [1:0] {
        SEL_NONE    = 2'b00,
        SEL_ID_HOLD = 2'b01,
        SEL_EX_HOLD = 2'b10
    } stall_sel_e;

    // Map a stall selection onto the stall bus pattern; unknown codes stall nothing
    function automatic logic [STALL_BUS_W-1:0] stall_pattern(input stall_sel_e sel);
        logic [STALL_BUS_W-1:0] pat;
        case (sel)
            SEL_NONE:    pat = STALL_NONE;
            SEL_ID_HOLD: pat = STALL_ID_HOLD;
            SEL_EX_HOLD: pat = STALL_EX_HOLD;
            default:     pat = STALL_NONE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer for the 5-stage pipeline. Merges the ID load-use
// request with the EX mul/div request, drives the stall bus, and sequences the
// external mul/div unit (start pulse, ready wait, timeout watchdog).
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W    = 6,
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stallreq_from_id_i,
    input  logic               stallreq_from_ex_i,
    input  logic               md_ready_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               md_start_o,
    output logic               md_busy_o,
    output logic [CNT_W-1:0]   md_cnt_o,
    output logic               md_timeout_o
);

    // Last WAIT count before the watchdog forces release, and the saturation ceiling
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic               md_timeout_q, md_timeout_d;
    stall_sel_e         stall_sel_s;
    logic               md_start_s;
    logic               md_busy_s;

    // State register, WAIT cycle counter and sticky watchdog flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= MDS_IDLE;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Next-state logic: launch on an EX request, wait for ready or the watchdog, retire
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        case (state_q)
            MDS_IDLE: begin
                if (stallreq_from_ex_i) begin
                    state_d = MDS_START;
                end else begin
                    state_d = MDS_IDLE;
                end
            end
            MDS_START: begin
                // The unit has not been started yet, so a ready here is meaningless
                state_d  = MDS_WAIT;
                md_cnt_d = '0;
            end
            MDS_WAIT: begin
                if (md_cnt_q != CNT_MAX) begin
                    md_cnt_d = md_cnt_q + CNT_ONE;
                end else begin
                    md_cnt_d = md_cnt_q;
                end
                if (md_ready_i) begin
                    state_d = MDS_DONE;
                end else if (md_cnt_q == CNT_LAST) begin
                    state_d      = MDS_DONE;
                    md_timeout_d = 1'b1;
                end else begin
                    state_d = MDS_WAIT;
                end
            end
            MDS_DONE: begin
                // The EX request still belongs to the op just finished
                state_d = MDS_IDLE;
            end
            default: begin
                state_d = MDS_IDLE;
            end
        endcase
    end

    // Output decode: stall selection is Mealy on the requests, start/busy are pure state
    always_comb begin
        stall_sel_s = SEL_NONE;
        md_start_s  = 1'b0;
        md_busy_s   = 1'b0;
        case (state_q)
            MDS_IDLE: begin
                if (stallreq_from_ex_i) begin
                    stall_sel_s = SEL_EX_HOLD;
                end else if (stallreq_from_id_i) begin
                    stall_sel_s = SEL_ID_HOLD;
                end else begin
                    stall_sel_s = SEL_NONE;
                end
            end
            MDS_START: begin
                stall_sel_s = SEL_EX_HOLD;
                md_start_s  = 1'b1;
                md_busy_s   = 1'b1;
            end
            MDS_WAIT: begin
                stall_sel_s = SEL_EX_HOLD;
                md_busy_s   = 1'b1;
            end
            MDS_DONE: begin
                // One free cycle so EX retires its result; a load-use still holds ID
                if (stallreq_from_id_i) begin
                    stall_sel_s = SEL_ID_HOLD;
                end else begin
                    stall_sel_s = SEL_NONE;
                end
            end
            default: begin
                stall_sel_s = SEL_NONE;
            end
        endcase
    end

    // Requests must not leak onto the stall bus while reset is held
    assign stall_o      = rst_ni ? STALL_W'(stall_pattern(stall_sel_s)) : '0;
    assign md_start_o   = rst_ni & md_start_s;
    assign md_busy_o    = rst_ni & md_busy_s;
    assign md_cnt_o     = md_cnt_q;
    assign md_timeout_o = md_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: each step drives the requests, queues
// the outputs expected for that cycle, and compares them mid-cycle.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;

    typedef struct {
        logic [5:0] stall;
        logic       start;
        logic       busy;
        logic [5:0] cnt;
        logic       tmo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_id;
    logic       req_ex;
    logic       rdy;
    logic [5:0] stall;
    logic       md_start;
    logic       md_busy;
    logic [5:0] md_cnt;
    logic       md_timeout;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;
    int         step  = 0;

    pipe_stall_ctrl #(
        .STALL_W    (6),
        .MD_TIMEOUT (40),
        .CNT_W      (6)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .stallreq_from_id_i (req_id),
        .stallreq_from_ex_i (req_ex),
        .md_ready_i         (rdy),
        .stall_o            (stall),
        .md_start_o         (md_start),
        .md_busy_o          (md_busy),
        .md_cnt_o           (md_cnt),
        .md_timeout_o       (md_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the outputs expected for the current cycle
    task automatic expect_out(input logic [5:0] s, input logic st, input logic bz,
                              input logic [5:0] c, input logic t);
        exp_t e;
        e.stall = s;
        e.start = st;
        e.busy  = bz;
        e.cnt   = c;
        e.tmo   = t;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic check_out();
        exp_t e;
        step++;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty step=%0d", step);
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (stall === e.stall) else begin
                bad++;
                $error("FAIL stall step=%0d got=%b exp=%b", step, stall, e.stall);
            end
            total++;
            assert (md_start === e.start) else begin
                bad++;
                $error("FAIL md_start step=%0d got=%b exp=%b", step, md_start, e.start);
            end
            total++;
            assert (md_busy === e.busy) else begin
                bad++;
                $error("FAIL md_busy step=%0d got=%b exp=%b", step, md_busy, e.busy);
            end
            total++;
            assert (md_cnt === e.cnt) else begin
                bad++;
                $error("FAIL md_cnt step=%0d got=%0d exp=%0d", step, md_cnt, e.cnt);
            end
            total++;
            assert (md_timeout === e.tmo) else begin
                bad++;
                $error("FAIL md_timeout step=%0d got=%b exp=%b", step, md_timeout, e.tmo);
            end
        end
    endtask

    // One clock cycle: drive just after the rising edge, check at the falling edge
    task automatic cyc(input logic id, input logic ex, input logic r,
                       input logic [5:0] s, input logic st, input logic bz,
                       input logic [5:0] c, input logic t);
        req_id = id;
        req_ex = ex;
        rdy    = r;
        expect_out(s, st, bz, c, t);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with both requests high: everything quiet
        rst_n  = 1'b0;
        req_id = 1'b1;
        req_ex = 1'b1;
        rdy    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_out(S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);
            @(negedge clk);
            check_out();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with no requests
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);

        // Load-use for one cycle, then released
        cyc(1'b1, 1'b0, 1'b0, S_ID,   1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);

        // Mul/div with ready 5 cycles after start, EX request held throughout
        cyc(1'b0, 1'b1, 1'b0, S_EX, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, S_EX, 1'b1, 1'b1, 6'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, S_EX, 1'b0, 1'b1, 6'(k), 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, S_EX,   1'b0, 1'b1, 6'd4, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, S_NONE, 1'b0, 1'b0, 6'd5, 1'b0);

        // Back-to-back op; ID absorbed and ready ignored in MD_START; shortest wait
        cyc(1'b0, 1'b1, 1'b0, S_EX, 1'b0, 1'b0, 6'd5, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, S_EX, 1'b1, 1'b1, 6'd5, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, S_EX, 1'b0, 1'b1, 6'd0, 1'b0);
        // MD_DONE: EX request ignored, ID request gives ID_HOLD
        cyc(1'b1, 1'b1, 1'b0, S_ID, 1'b0, 1'b0, 6'd1, 1'b0);

        // Both requests in IDLE: EX wins, then watchdog op with no ready
        cyc(1'b1, 1'b1, 1'b0, S_EX, 1'b0, 1'b0, 6'd1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, S_EX, 1'b1, 1'b1, 6'd1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b0, 1'b0, S_EX, 1'b0, 1'b1, 6'(k), 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd40, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd40, 1'b1);

        // A later normal op: sticky flag stays set
        cyc(1'b0, 1'b1, 1'b0, S_EX,   1'b0, 1'b0, 6'd40, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_EX,   1'b1, 1'b1, 6'd40, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_EX,   1'b0, 1'b1, 6'd0,  1'b1);
        cyc(1'b0, 1'b0, 1'b1, S_EX,   1'b0, 1'b1, 6'd1,  1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd2,  1'b1);

        // Reset in the middle of MD_WAIT
        cyc(1'b0, 1'b1, 1'b0, S_EX, 1'b0, 1'b0, 6'd2, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_EX, 1'b1, 1'b1, 6'd2, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, S_EX, 1'b0, 1'b1, 6'd0, 1'b1);
        req_id = 1'b1;
        req_ex = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        expect_out(S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, S_EX,   1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, S_EX,   1'b1, 1'b1, 6'd0, 1'b0);

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
